// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: opcodes, FSM states and helpers shared by the serial ALU sequencer
package alu_serial_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic logic is_arith(input logic [1:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction
endpackage

// File: rtl/alu_serial_ctrl_if.sv
// alu_serial_ctrl_if: request and result handshakes of the serial ALU sequencer
interface alu_serial_ctrl_if #(parameter int WIDTH = 8);
    logic             in_valid, in_ready, in_cin;
    logic [WIDTH-1:0] in_a, in_b;
    logic [1:0]       in_op;
    logic             out_valid, out_ready, out_cout;
    logic [WIDTH-1:0] out_result;
    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_result, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_result, out_cout
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: feeds an external 1-bit ALU slice LSB first, chaining its carry
// and collecting result bits into a WIDTH-bit result.
module alu_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) > 0 ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_ctrl_if.slave   bus,
    output logic               alu_a,
    output logic               alu_b,
    output logic [1:0]         alu_op,
    output logic               alu_cin,
    input  logic               alu_result,
    input  logic               alu_cout
);
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             carry, carry_next, run, last;

    assign run        = state == RUN;
    assign last       = cnt == CNT_W'(WIDTH - 1);
    assign res_next   = (res_sr >> 1) | (WIDTH'(alu_result) << (WIDTH - 1));
    assign carry_next = is_arith(op) & alu_cout;

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;

    // SUB runs as A + ~B + 1 with the slice in ADD mode
    assign alu_a   = run & a_sr[0];
    assign alu_b   = run & (b_sr[0] ^ (op == OP_SUB));
    assign alu_op  = (run && op != OP_SUB) ? op : OP_ADD;
    assign alu_cin = run & is_arith(op) & carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            a_sr           <= '0;
            b_sr           <= '0;
            res_sr         <= '0;
            op             <= OP_ADD;
            cnt            <= '0;
            carry          <= 1'b0;
            bus.out_result <= '0;
            bus.out_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_sr  <= bus.in_a;
                    b_sr  <= bus.in_b;
                    op    <= bus.in_op;
                    carry <= (bus.in_op == OP_ADD) ? bus.in_cin : (bus.in_op == OP_SUB);
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= carry_next;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        bus.out_result <= res_next;
                        bus.out_cout   <= carry_next;
                        state          <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: runs WIDTH=1, 8 and 16 sequencers side by side against a
// behavioural slice and an arithmetic reference model.
module tb_alu_serial_ctrl;
    import alu_serial_pkg::*;

    localparam int WS[3] = '{1, 8, 16};

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, in_cin = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic [1:0]  in_op = OP_ADD;
    logic        ov[3], ir[3], oc[3], aa[3], ab[3], acin[3], ar[3], ac[3];
    logic [1:0]  aop[3];
    logic [15:0] res[3];
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] slice(input logic a, b, input logic [1:0] o, input logic c);
        return o[1] ? {1'b0, o[0] ? (a | b) : (a & b)} : {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

    function automatic logic [16:0] model(input int w, input logic [1:0] o,
                                          input logic [15:0] a, b, input logic c);
        logic [31:0] m, x, y, s, r;
        m = (32'd1 << w) - 1;
        x = {16'd0, a} & m;
        y = {16'd0, b} & m;
        s = o == OP_ADD ? x + y + {31'd0, c} :
            o == OP_SUB ? x + (~y & m) + 32'd1 :
            o == OP_AND ? x & y : x | y;
        r = s & m;
        return {s[w], r[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = g == 0 ? 1 : g == 1 ? 8 : 16;
        alu_serial_ctrl_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_a      = in_a[W-1:0];
        assign bus.in_b      = in_b[W-1:0];
        assign bus.in_op     = in_op;
        assign bus.in_cin    = in_cin;
        assign bus.out_ready = out_ready;
        assign ov[g]  = bus.out_valid;
        assign ir[g]  = bus.in_ready;
        assign oc[g]  = bus.out_cout;
        assign res[g] = 16'(bus.out_result);
        assign {ac[g], ar[g]} = slice(aa[g], ab[g], aop[g], acin[g]);
        alu_serial_ctrl #(.WIDTH(W)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus),
            .alu_a(aa[g]), .alu_b(ab[g]), .alu_op(aop[g]), .alu_cin(acin[g]),
            .alu_result(ar[g]), .alu_cout(ac[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, b, input logic c, input string tag);
        int lat[3];
        int k;
        logic [16:0] e;
        lat = '{0, 0, 0};
        in_op = o; in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        k = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (k < 40) begin
            for (int g = 0; g < 3; g++) if (ov[g] && lat[g] == 0) lat[g] = k;
            if (!ir[1] && !ov[1]) begin
                chk({tag, " alu_op"}, 32'(aop[1]), 32'(o[1] ? o : OP_ADD));
                if (o[1]) chk({tag, " alu_cin"}, 32'(acin[1]), 32'd0);
            end
            if (ov[0] && ov[1] && ov[2]) break;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            e = model(WS[g], o, a, b, c);
            chk($sformatf("%s w%0d latency", tag, WS[g]), 32'(lat[g]), 32'(WS[g] + 1));
            chk($sformatf("%s w%0d result", tag, WS[g]), 32'(res[g]), 32'(e[15:0]));
            chk($sformatf("%s w%0d cout", tag, WS[g]), 32'(oc[g]), 32'(e[16]));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int g = 0; g < 3; g++) chk($sformatf("%s w%0d in_ready", tag, WS[g]), 32'(ir[g]), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_ready"}, 32'(ir[1]), 32'd1);
        chk({tag, " out_valid"}, 32'(ov[1]), 32'd0);
        chk({tag, " out_result"}, 32'(res[1]), 32'd0);
        chk({tag, " out_cout"}, 32'(oc[1]), 32'd0);
        chk({tag, " alu_bits"}, 32'({aa[1], ab[1], acin[1], aop[1]}), 32'd0);
        chk({tag, " w16 result"}, 32'(res[2]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc[$];
        logic [15:0] rq[$];
        logic [15:0] b16;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_ADD, 16'h007F, 16'h0001, 1'b0, "add7f");  release_out("add7f");
        run_op(OP_ADD, 16'h00FF, 16'h0001, 1'b1, "addff");  release_out("addff");
        run_op(OP_SUB, 16'h0005, 16'h0007, 1'b0, "sub57");  release_out("sub57");
        run_op(OP_SUB, 16'h0007, 16'h0005, 1'b0, "sub75");  release_out("sub75");
        run_op(OP_AND, 16'h00A5, 16'h003C, 1'b1, "and");    release_out("and");
        run_op(OP_OR,  16'h00A5, 16'h003C, 1'b1, "or");     release_out("or");

        run_op(OP_ADD, 16'h0012, 16'h0034, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op = OP_OR; in_a = 16'hFFFF; in_b = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp out_valid", 32'(ov[1]), 32'd1);
            chk("bp out_result", 32'(res[1]), 32'h46);
            chk("bp in_ready", 32'(ir[1]), 32'd0);
        end
        release_out("bp");
        chk("bp out_valid after", 32'(ov[1]), 32'd0);
        chk("bp result held", 32'(res[1]), 32'h46);

        in_op = OP_ADD; in_a = 16'h0055; in_b = 16'h000F; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, "after_rst");
        release_out("after_rst");

        in_op = OP_ADD; in_a = 16'h0011; in_b = 16'h0022; in_cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (ov[1]) rq.push_back(res[1]);
            if (ir[1] && in_valid) acc.push_back(k);
            if (acc.size() == 1 && k > acc[0]) begin
                in_op = OP_SUB; in_a = 16'h0030; in_b = 16'h0040;
            end
            if (acc.size() == 2 && k > acc[1]) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b accepts", 32'(acc.size()), 32'd2);
        chk("b2b interval", acc.size() >= 2 ? 32'(acc[1] - acc[0]) : 32'hFFFF_FFFF, 32'd10);
        chk("b2b result0", rq.size() > 0 ? 32'(rq[0]) : 32'hFFFF_FFFF, 32'h33);
        chk("b2b result1", rq.size() > 1 ? 32'(rq[1]) : 32'hFFFF_FFFF, 32'hF0);

        for (int i = 0; i < 25; i++) begin
            b16 = 16'($urandom);
            run_op(2'($urandom_range(0, 3)), 16'($urandom), i % 5 == 0 ? 16'hFFFF : b16,
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
            release_out("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
